// File: rtl/dpr_pkg.sv
// Shared widths and types for the dual-port scratch RAM.
// Optional feature macro: DPR_WRITE_THROUGH_EN.
package dpr_pkg;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef logic [DW-1:0] word_t;
  typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/dpr_if.sv
// Port-0 read/write and port-1 read bus of the dual-port RAM.
// Optional feature macro: DPR_WRITE_THROUGH_EN.
interface dpr_if;
  import dpr_pkg::*;

  logic  WEN;
  word_t DI;
  addr_t A0;
  addr_t A1;
  logic  PEN0;
  logic  PEN1;
  word_t DO0;
  word_t DO1;

  modport master (
    output WEN, DI, A0, A1, PEN0, PEN1,
    input  DO0, DO1
  );

  modport slave (
    input  WEN, DI, A0, A1, PEN0, PEN1,
    output DO0, DO1
  );

endinterface

// File: rtl/dpr_read_port.sv
// Registered read-only port: enable-hold and optional new-data bypass.
// Optional feature macro: DPR_WRITE_THROUGH_EN.
module dpr_read_port
  import dpr_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  word_t rd_word,
  input  logic  wr_hit,
  input  word_t wr_data,
  output word_t dout
);

  word_t dout_q;
  word_t dout_d;
  word_t src;

`ifdef DPR_WRITE_THROUGH_EN
  assign src = wr_hit ? wr_data : rd_word;
`else
  logic unused_byp;
  assign unused_byp = ^{wr_hit, wr_data};
  assign src = rd_word;
`endif

  always_comb begin
    dout_d = dout_q;
    if (en)
      dout_d = src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dout_q <= '0;
    else
      dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/dpr_design.sv
// Single-clock DEPTH x DW dual-port RAM; port 0 r/w, port 1 read-only.
// Optional feature macro: DPR_WRITE_THROUGH_EN.
module dpr_design
  import dpr_pkg::*;
(
  input  logic   CLK,
  input  logic   RST_N,
  dpr_if.slave   bus
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  word_t do0_q;
  word_t do0_d;

  logic wr0;
  logic rd0;
  logic hit;

  assign wr0 = bus.PEN0 & bus.WEN;
  assign rd0 = bus.PEN0 & ~bus.WEN;
  assign hit = wr0 & (bus.A0 == bus.A1);

  always_comb begin
    mem_d = mem_q;
    if (wr0)
      mem_d[bus.A0] = bus.DI;
  end

  always_comb begin
    do0_d = do0_q;
    unique case (1'b1)
      rd0:     do0_d = mem_q[bus.A0];
`ifdef DPR_WRITE_THROUGH_EN
      wr0:     do0_d = bus.DI;
`endif
      default: do0_d = do0_q;
    endcase
  end

  // Whole array clears on reset so a mid-run reset drops any pending write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_q <= '{default: '0};
      do0_q <= '0;
    end else begin
      mem_q <= mem_d;
      do0_q <= do0_d;
    end
  end

  assign bus.DO0 = do0_q;

  dpr_read_port u_rd1 (
    .clk     (CLK),
    .rst_n   (RST_N),
    .en      (bus.PEN1),
    .rd_word (mem_q[bus.A1]),
    .wr_hit  (hit),
    .wr_data (bus.DI),
    .dout    (bus.DO1)
  );

endmodule

// File: tb/tb_dpr_design.sv
// Directed bench for dpr_design; honours DPR_WRITE_THROUGH_EN if defined.
// Inputs change on the falling edge, outputs are checked on the falling edge.
module tb_dpr_design;
  import dpr_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  dpr_if bus ();

  dpr_design dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.WEN  = 1'b0;
    bus.DI   = '0;
    bus.A0   = '0;
    bus.A1   = '0;
    bus.PEN0 = 1'b0;
    bus.PEN1 = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if (bus.DO0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_do0 got=%h exp=00", bus.DO0);
    end
    checks++;
    if (bus.DO1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_do1 got=%h exp=00", bus.DO1);
    end
    rst_n = 1'b1;
    bus.PEN0 = 1'b1;
    bus.PEN1 = 1'b1;
    bus.A0 = 4'd0;
    bus.A1 = 4'd15;
    cyc();
    checks++;
    if (bus.DO0 !== 8'h00 || bus.DO1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem got=%h/%h exp=00/00", bus.DO0, bus.DO1);
    end
    idle();
  endtask

  task automatic test_fill_sweep();
    bus.PEN0 = 1'b1;
    bus.WEN  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.A0 = 4'(i - 1);
      bus.DI = 8'(i);
      cyc();
    end
    idle();
    bus.PEN1 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.A1 = 4'(a);
      cyc();
      checks++;
      if (bus.DO1 !== 8'(a + 1)) begin
        errors++;
        $display("FAIL sweep_a%0d got=%h exp=%h", a, bus.DO1, 8'(a + 1));
      end
    end
    bus.PEN1 = 1'b0;
    bus.A1 = 4'd2;
    cyc();
    checks++;
    if (bus.DO1 !== 8'd16) begin
      errors++;
      $display("FAIL do1_hold got=%h exp=10", bus.DO1);
    end
  endtask

  task automatic test_port0_read();
    bus.PEN0 = 1'b1;
    bus.WEN  = 1'b0;
    bus.A0   = 4'd5;
    cyc();
    checks++;
    if (bus.DO0 !== 8'd6) begin
      errors++;
      $display("FAIL p0_read got=%h exp=06", bus.DO0);
    end
    bus.PEN0 = 1'b0;
    for (int a = 10; a < 13; a++) begin
      bus.A0 = 4'(a);
      cyc();
      checks++;
      if (bus.DO0 !== 8'd6) begin
        errors++;
        $display("FAIL p0_hold_a%0d got=%h exp=06", a, bus.DO0);
      end
    end
  endtask

  task automatic test_wen_ignored();
    bus.PEN0 = 1'b0;
    bus.WEN  = 1'b1;
    bus.DI   = 8'hAA;
    bus.A0   = 4'd3;
    cyc();
    checks++;
    if (bus.DO0 !== 8'd6) begin
      errors++;
      $display("FAIL wen_no_pen_do0 got=%h exp=06", bus.DO0);
    end
    bus.PEN0 = 1'b1;
    bus.WEN  = 1'b0;
    cyc();
    checks++;
    if (bus.DO0 !== 8'd4) begin
      errors++;
      $display("FAIL wen_no_pen_mem got=%h exp=04", bus.DO0);
    end
    idle();
  endtask

  task automatic test_collision();
    bus.PEN0 = 1'b1;
    bus.WEN  = 1'b1;
    bus.DI   = 8'h55;
    bus.A0   = 4'd7;
    bus.PEN1 = 1'b1;
    bus.A1   = 4'd7;
    cyc();
`ifdef DPR_WRITE_THROUGH_EN
    checks++;
    if (bus.DO1 !== 8'h55) begin
      errors++;
      $display("FAIL coll_do1 got=%h exp=55", bus.DO1);
    end
    checks++;
    if (bus.DO0 !== 8'h55) begin
      errors++;
      $display("FAIL coll_do0 got=%h exp=55", bus.DO0);
    end
`else
    checks++;
    if (bus.DO1 !== 8'h08) begin
      errors++;
      $display("FAIL coll_do1 got=%h exp=08", bus.DO1);
    end
    checks++;
    if (bus.DO0 !== 8'h04) begin
      errors++;
      $display("FAIL coll_do0_hold got=%h exp=04", bus.DO0);
    end
`endif
    bus.PEN0 = 1'b1;
    bus.WEN  = 1'b0;
    bus.A0   = 4'd6;
    cyc();
    checks++;
    if (bus.DO1 !== 8'h55) begin
      errors++;
      $display("FAIL coll_next got=%h exp=55", bus.DO1);
    end
    checks++;
    if (bus.DO0 !== 8'h07) begin
      errors++;
      $display("FAIL coll_nbr got=%h exp=07", bus.DO0);
    end
    idle();
  endtask

  task automatic test_same_addr_read();
    bus.PEN0 = 1'b1;
    bus.PEN1 = 1'b1;
    bus.WEN  = 1'b0;
    bus.A0   = 4'd9;
    bus.A1   = 4'd9;
    cyc();
    checks++;
    if (bus.DO0 !== 8'd10 || bus.DO1 !== 8'd10) begin
      errors++;
      $display("FAIL same_addr got=%h/%h exp=0a/0a", bus.DO0, bus.DO1);
    end
  endtask

  task automatic test_reset_mid();
    bus.PEN0 = 1'b1;
    bus.WEN  = 1'b1;
    bus.DI   = 8'hC3;
    bus.A0   = 4'd1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.DO0 !== 8'h00 || bus.DO1 !== 8'h00) begin
      errors++;
      $display("FAIL async_rst got=%h/%h exp=00/00", bus.DO0, bus.DO1);
    end
    cyc();
    idle();
    cyc();
    rst_n = 1'b1;
    bus.PEN0 = 1'b1;
    bus.PEN1 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.A0 = 4'(a);
      bus.A1 = 4'(15 - a);
      cyc();
      checks++;
      if (bus.DO0 !== 8'h00 || bus.DO1 !== 8'h00) begin
        errors++;
        $display("FAIL clr_a%0d got=%h/%h exp=00/00", a, bus.DO0, bus.DO1);
      end
    end
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_fill_sweep();
    test_port0_read();
    test_wen_ignored();
    test_collision();
    test_same_addr_read();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
